mult_booth4_seq: RTL and testbench

MULT_BOOTH4_SEQ -- requirements
Module: mult_booth4_seq

---
 rtl/mult_pkg.sv | 31 +++
 rtl/booth4_pp_gen.sv | 32 +++
 rtl/mult_booth4_seq.sv | 113 +++++++++++
 tb/tb_mult_booth4_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM state and radix-4 Booth digit select codes
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_POS1 = 3'd1,
        SEL_POS2 = 3'd2,
        SEL_NEG1 = 3'd3,
        SEL_NEG2 = 3'd4
    } booth_sel_t;

    // Window is {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_sel_t booth_decode(input logic [2:0] win);
        booth_sel_t sel;
        case (win)
            3'b001, 3'b010: sel = SEL_POS1;
            3'b011:         sel = SEL_POS2;
            3'b100:         sel = SEL_NEG2;
            3'b101, 3'b110: sel = SEL_NEG1;
            default:        sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth4_pp_gen.sv
// rtl/booth4_pp_gen.sv - radix-4 Booth digit decode and signed partial product
module booth4_pp_gen
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       i_window,
    input  logic [WIDTH+1:0] i_a_ext,
    output logic [WIDTH+2:0] o_pp
);

    booth_sel_t       w_sel;
    logic [WIDTH+2:0] w_a1;
    logic [WIDTH+2:0] w_a2;

    assign w_sel = booth_decode(i_window);
    // One extra bit so that +-2A of the extended multiplicand cannot overflow
    assign w_a1  = {i_a_ext[WIDTH+1], i_a_ext};
    assign w_a2  = {i_a_ext, 1'b0};

    always_comb begin
        o_pp = '0;
        case (w_sel)
            SEL_POS1: o_pp = w_a1;
            SEL_POS2: o_pp = w_a2;
            SEL_NEG1: o_pp = {(WIDTH+3){1'b0}} - w_a1;
            SEL_NEG2: o_pp = {(WIDTH+3){1'b0}} - w_a2;
            default:  o_pp = '0;
        endcase
    end

endmodule

// File: rtl/mult_booth4_seq.sv
// rtl/mult_booth4_seq.sv - sequential radix-4 Booth multiplier, one digit per cycle
module mult_booth4_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 SIGNED_MODE,
    input  logic [WIDTH-1:0]     A_NUM,
    input  logic [WIDTH-1:0]     B_NUM,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   C_NUM
);

    localparam int NDIG  = WIDTH / 2 + 1;
    localparam int ACC_W = 2 * WIDTH + 2;
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH+1:0]   r_a_ext;
    logic [WIDTH+2:0]   r_b_win;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_c;

    logic               w_accept;
    logic [1:0]         w_a_sx;
    logic [1:0]         w_b_sx;
    logic [WIDTH+2:0]   w_pp;
    logic [ACC_W-1:0]   w_pp_wide;
    logic [ACC_W-1:0]   w_pp_shift;
    logic [ACC_W-1:0]   w_acc_next;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_a_sx   = {2{SIGNED_MODE & A_NUM[WIDTH-1]}};
    assign w_b_sx   = {2{SIGNED_MODE & B_NUM[WIDTH-1]}};

    booth4_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .i_window (r_b_win[2:0]),
        .i_a_ext  (r_a_ext),
        .o_pp     (w_pp)
    );

    assign w_pp_wide  = {{(ACC_W-WIDTH-3){w_pp[WIDTH+2]}}, w_pp};
    assign w_pp_shift = w_pp_wide << {r_cnt, 1'b0};
    assign w_acc_next = r_acc + w_pp_shift;

    // Operand storage: the multiplier is kept with an implicit 0 below its LSB
    // and shifted two bits per retired digit so the window is always [2:0].
    always_ff @(posedge sys_clk) begin
        if (w_accept) begin
            r_a_ext <= {w_a_sx, A_NUM};
            r_b_win <= {w_b_sx, B_NUM, 1'b0};
        end else if (r_state == ST_BUSY) begin
            r_b_win <= r_b_win >> 2;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_c         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state    <= ST_BUSY;
                        r_in_ready <= 1'b0;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                    end
                end
                ST_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_DIG) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_c         <= w_acc_next[2*WIDTH-1:0];
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign C_NUM     = r_c;

endmodule

// File: tb/tb_mult_booth4_seq.sv
// tb/tb_mult_booth4_seq.sv - scoreboard bench for mult_booth4_seq at WIDTH=16
module tb_mult_booth4_seq;

    localparam int WIDTH = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              signed_mode = 1'b0;
    logic [WIDTH-1:0]  a_num = '0;
    logic [WIDTH-1:0]  b_num = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2*WIDTH-1:0] c_num;

    int checks   = 0;
    int failures = 0;

    logic [2*WIDTH-1:0] exp_q[$];
    logic [2*WIDTH-1:0] last_exp;
    bit hold_ready = 1'b1;
    bit stall_en   = 1'b0;

    mult_booth4_seq #(.WIDTH(WIDTH)) dut (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .SIGNED_MODE (signed_mode),
        .A_NUM       (a_num),
        .B_NUM       (b_num),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .C_NUM       (c_num)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Sole driver of out_ready
    always @(posedge clk) begin
        #2;
        if (hold_ready)    out_ready = 1'b0;
        else if (stall_en) out_ready = ($urandom_range(0, 3) != 0);
        else               out_ready = 1'b1;
    end

    // Monitor: a handshake seen at negedge completes on the next posedge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_product", {32'd0, c_num}, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                chk("product", {32'd0, c_num}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic [2*WIDTH-1:0] exp, input bit push);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 300) chk("in_ready_timeout", 64'd0, 64'd1);
        a_num = a; b_num = b; signed_mode = s; in_valid = 1'b1;
        if (push) begin
            exp_q.push_back(exp);
            last_exp = exp;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b, input logic s);
        logic signed [2*WIDTH-1:0] sp;
        logic [2*WIDTH-1:0] up;
        sp = $signed(a) * $signed(b);
        up = a * b;
        return s ? sp : up;
    endfunction

    task automatic wait_drain();
        int n;
        for (n = 0; n < 2000 && exp_q.size() != 0; n++) @(posedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lat;
        bit seen;
        logic [WIDTH-1:0] ra, rb;
        logic rs;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_c_num", {32'd0, c_num}, 64'd0);
        hold_ready = 1'b0;

        // Latency: out_valid 9 edges after the accepting edge
        send(16'h3524, 16'h5E81, 1'b0, 32'h139DFF24, 1'b1);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin lat = n; break; end
        end
        chk("latency_cycles", 64'(lat), 64'd9);
        wait_drain();
        @(posedge clk);
        #1;
        chk("idle_holds_c", {32'd0, c_num}, 64'h139DFF24);

        send(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b1);
        send(16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1);
        send(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 1'b1);
        send(16'h0000, 16'h1234, 1'b1, 32'h00000000, 1'b1);
        send(16'h0003, 16'hFFFE, 1'b1, 32'hFFFFFFFA, 1'b1);
        send(16'h0003, 16'hFFFE, 1'b0, 32'h0002FFFA, 1'b1);
        wait_drain();

        // Stall in DONE while the input side keeps trying
        hold_ready = 1'b1;
        send(16'h0100, 16'h0100, 1'b0, 32'h00010000, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk);
            #1;
            seen = out_valid;
        end
        chk("hold_reach_done", {63'd0, seen}, 64'd1);
        for (int n = 0; n < 5; n++) begin
            in_valid = n[0] ? 1'b0 : 1'b1;
            a_num = 16'($urandom); b_num = 16'($urandom); signed_mode = n[1];
            @(posedge clk);
            #1;
            chk("hold_c_stable", {32'd0, c_num}, 64'h00010000);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        hold_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("release_out_valid", {63'd0, out_valid}, 64'd0);
        chk("release_queue", 64'(exp_q.size()), 64'd0);

        // Reset while retiring digit 4: operation is discarded
        send(16'h1111, 16'h2222, 1'b0, 32'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_c_num", {32'd0, c_num}, 64'd0);
        seen = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_valid", {63'd0, seen}, 64'd0);
        send(16'h1234, 16'h5678, 1'b0, 32'h06260060, 1'b1);
        wait_drain();

        // Model-checked pairs with random consumer stalls
        stall_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            if (i < 4) begin
                ra = (i[0]) ? 16'h8000 : 16'h7FFF;
                rb = (i[1]) ? 16'h8000 : 16'hFFFF;
            end
            send(ra, rb, rs, ref_mul(ra, rb, rs), 1'b1);
        end
        wait_drain();
        stall_en = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
